seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
- Parametrised, run-time programmable serial sequence detector; successor to the fixed-pattern 3-bit Moore detector.
- Matches a PAT_W-bit pattern on a qualified serial bit stream, with overlapping or non-overlapping mode.
- Registered (Moore) one-cycle match pulse plus a saturating match counter.
- Sits between a serial front end and the status/interrupt logic.

Parameters:
PAT_W, 3, pattern length in bits (legal range 2..16)
PAT_RST, 3'b101 (PAT_W bits), pattern value loaded at reset
CNT_W, 8, match counter width

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
w  input  1  serial data bit
w_valid  input  1  w is sampled this cycle when high
pattern  input  PAT_W  new pattern; MSB is the first bit in time
pat_load  input  1  load pattern, restart detection
overlap  input  1  1 = overlapping matches, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match counter and sat
out  output  1  match pulse, registered
match_cnt  output  CNT_W  number of matches since reset/clear
sat  output  1  sticky, match_cnt has saturated

Behaviour:
- One clock; reset is asynchronous and active-low (clr low clears all state immediately, independent of clk).
- Reset values: pat_q=PAT_RST, hist_q=0, fill_q=0, out=0, match_cnt=0, sat=0.
- State: pat_q[PAT_W], hist_q[PAT_W] (newest bit in LSB), fill_q[$clog2(PAT_W+1)] = valid history bits, out, match_cnt, sat.
- Priority per rising edge: pat_load > w_valid > idle.
- pat_load:
  - pat_q<=pattern; hist_q<=0; fill_q<=0; out<=0.
  - w and w_valid in the same cycle are ignored.
  - match_cnt is unchanged.
- w_valid (no pat_load):
  - hist_n={hist_q[PAT_W-2:0],w}.
  - fill_n=min(fill_q+1,PAT_W).
  - hit=(fill_n==PAT_W)&&(hist_n==pat_q).
  - hist_q<=hist_n; out<=hit.
  - If hit and overlap==0: fill_q<=0. Otherwise fill_q<=fill_n.
- Idle cycle (w_valid=0): out<=0; hist_q and fill_q hold. Gaps in w_valid never break a partial match.
- Latency: out is high exactly in the cycle after the edge that samples the completing bit; it is a one-cycle pulse per match. Back-to-back overlapping matches give consecutive high cycles.
- Before PAT_W bits have been accepted after reset or pat_load, no match is possible even if the zero-initialised history equals the pattern.
- overlap is sampled on each w_valid edge. Switching it mid-stream affects only the next hit.
- Counter:
  - On hit, match_cnt increments unless already all-ones.
  - A hit while match_cnt is all-ones sets sat (sticky); match_cnt holds at all-ones.
  - cnt_clr: match_cnt<=0, sat<=0. cnt_clr wins over a simultaneous hit (result 0); out still pulses.
- Async reset mid-stream discards any partial match. The first possible hit is PAT_W accepted bits after clr deasserts.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

Decomposition:
- Package seq_detect_pkg: mode constants OVL_ON=1'b1, OVL_OFF=1'b0; a function returning the fill counter width for PAT_W.
- Sub-module seq_hist_shreg: PAT_W-bit history shift register with fill counter and synchronous restart. The top level holds pat_q, the compare, out, and the counter/sat logic.

Test Plan:
- Defaults, overlap=1, stream 1,0,1,0,1 on consecutive cycles -> out high in cycles after bits 3 and 5; match_cnt=2.
- Same stream, overlap=0 -> single pulse after bit 3; bits 4-5 do not match; match_cnt=1.
- overlap=1, stream 1,(w_valid low 3 cycles),0,1 -> one pulse after the final 1; no out during gaps; match_cnt=1.
- After 1,0 accepted, pat_load with pattern=3'b110, then 1,1,0 -> no pulse from the old partial; pulse after the final 0; pat_q=110.
- CNT_W=2, overlap=1, pattern 101, stream 1,0,1,0,1,0,1,0,1 (4 hits) -> match_cnt 1,2,3,3; sat set on the 4th hit. cnt_clr together with a hit -> match_cnt=0, sat=0, out pulses.
- Assert clr low asynchronously between edges after 1,0 accepted -> out, match_cnt, fill_q go 0 immediately. After release, 1 alone gives no pulse; 1,0,1 pulses once.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared mode constants and sizing helper for the programmable sequence detector
package seq_detect_pkg;
  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_hist_shreg.sv
// seq_hist_shreg: serial history shift register with saturating fill count and synchronous restart
module seq_hist_shreg #(
  parameter int PAT_W  = 3,
  parameter int FILL_W = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              restart,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              drop_fill,
  output logic [PAT_W-1:0]  hist_n,
  output logic [FILL_W-1:0] fill_n
);
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], bit_in};
    fill_n = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hist_d = restart ? '0 : shift ? hist_n : hist_q;
    fill_d = restart ? '0 : shift ? (drop_fill ? '0 : fill_n) : fill_q;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: run-time programmable serial pattern detector with registered match pulse and saturating counter
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             w,
  input  logic             w_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sat
);
  localparam int FILL_W = fill_width(PAT_W);
  logic [PAT_W-1:0]  pat_q, pat_d, hist_n;
  logic [FILL_W-1:0] fill_n;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, sat_q, sat_d, shift, hit, drop_fill;
  seq_hist_shreg #(.PAT_W(PAT_W), .FILL_W(FILL_W)) u_hist (
    .clk      (clk),
    .clr      (clr),
    .restart  (pat_load),
    .shift    (shift),
    .bit_in   (w),
    .drop_fill(drop_fill),
    .hist_n   (hist_n),
    .fill_n   (fill_n)
  );
  // a hit only counts once the history holds PAT_W genuinely accepted bits
  always_comb begin
    shift     = w_valid && !pat_load;
    hit       = shift && (fill_n == FILL_W'(PAT_W)) && (hist_n == pat_q);
    drop_fill = hit && (overlap == OVL_OFF);
    pat_d     = pat_load ? pattern : pat_q;
    cnt_d     = cnt_clr ? '0 : (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    sat_d     = cnt_clr ? 1'b0 : sat_q | (hit && (&cnt_q));
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pat_q <= PAT_RST;
      out_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
      out_q <= hit;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end
  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign sat       = sat_q;
endmodule
